// File: rtl/bitwise_oper_sched.sv
// bitwise_oper_sched
// Round-robin arbiter and IDLE/BUSY sequencer that shares one multi-cycle
// AND/OR/XOR unit among NREQ requesters. A granted request has its operands
// and id captured, waits DELAY cycles, then presents all three results
// together with a one-cycle done pulse and the requester id.

module bitwise_oper_sched #(
    parameter int WIDTH = 16,
    parameter int NREQ  = 4,
    parameter int ID_W  = 2,
    parameter int DELAY = 10
) (
    input  logic                    clock,
    input  logic                    reset_n,
    input  logic [NREQ-1:0]         req,
    input  logic [NREQ*WIDTH-1:0]   a_bus,
    input  logic [NREQ*WIDTH-1:0]   b_bus,
    output logic [NREQ-1:0]         gnt,
    output logic                    busy,
    output logic                    done,
    output logic [ID_W-1:0]         done_id,
    output logic [WIDTH-1:0]        ab_and,
    output logic [WIDTH-1:0]        ab_or,
    output logic [WIDTH-1:0]        ab_xor
);

    // Parameter sanity: a zero latency or an id field too narrow cannot work.
    if (DELAY < 1 || DELAY > 255) begin : g_bad_delay
        $error("bitwise_oper_sched: DELAY must be in 1..255");
    end
    if (NREQ < 2 || NREQ > 16) begin : g_bad_nreq
        $error("bitwise_oper_sched: NREQ must be in 2..16");
    end
    if ((2 ** ID_W) < NREQ) begin : g_bad_idw
        $error("bitwise_oper_sched: ID_W too small for NREQ");
    end

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [ID_W-1:0]        ptr_q, ptr_d;
    logic [7:0]             cnt_q, cnt_d;
    logic [WIDTH-1:0]       op_a_q, op_a_d;
    logic [WIDTH-1:0]       op_b_q, op_b_d;
    logic [ID_W-1:0]        id_q, id_d;
    logic [NREQ-1:0]        gnt_q, gnt_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [ID_W-1:0]        done_id_q, done_id_d;
    logic [WIDTH-1:0]       and_q, and_d;
    logic [WIDTH-1:0]       or_q, or_d;
    logic [WIDTH-1:0]       xor_q, xor_d;

    // Per-requester operand views of the flat buses.
    logic [WIDTH-1:0]       a_slice [NREQ];
    logic [WIDTH-1:0]       b_slice [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_slice
            assign a_slice[gi] = a_bus[gi*WIDTH +: WIDTH];
            assign b_slice[gi] = b_bus[gi*WIDTH +: WIDTH];
        end
    endgenerate

    logic                   sel_valid;
    logic [ID_W-1:0]        sel_idx;
    logic [ID_W:0]          cand;

    // Round-robin pick: first asserted request scanning ptr, ptr+1, ... mod NREQ.
    always_comb begin
        sel_valid = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand >= (ID_W+1)'(NREQ)) begin
                cand = cand - (ID_W+1)'(NREQ);
            end
            if (!sel_valid && req[cand[ID_W-1:0]]) begin
                sel_valid = 1'b1;
                sel_idx   = cand[ID_W-1:0];
            end
        end
    end

    // Sequencer next-state: grant and capture in IDLE, count down and publish in BUSY.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        id_d      = id_q;
        gnt_d     = '0;
        busy_d    = busy_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        and_d     = and_q;
        or_d      = or_q;
        xor_d     = xor_q;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    op_a_d  = a_slice[sel_idx];
                    op_b_d  = b_slice[sel_idx];
                    id_d    = sel_idx;
                    gnt_d   = NREQ'(1) << sel_idx;
                    busy_d  = 1'b1;
                    cnt_d   = 8'(DELAY - 1);
                    ptr_d   = (sel_idx == ID_W'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else begin
                    and_d     = op_a_q & op_b_q;
                    or_d      = op_a_q | op_b_q;
                    xor_d     = op_a_q ^ op_b_q;
                    done_id_d = id_q;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight operation.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            id_q      <= '0;
            gnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
            and_q     <= '0;
            or_q      <= '0;
            xor_q     <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            id_q      <= id_d;
            gnt_q     <= gnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            and_q     <= and_d;
            or_q      <= or_d;
            xor_q     <= xor_d;
        end
    end

    assign gnt     = gnt_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign done_id = done_id_q;
    assign ab_and  = and_q;
    assign ab_or   = or_q;
    assign ab_xor  = xor_q;

endmodule

// File: tb/tb_bitwise_oper_sched.sv
// Testbench for bitwise_oper_sched: directed steps with a scoreboard of
// expected completions, plus a second instance built with DELAY=1.

module tb_bitwise_oper_sched;

    localparam int WIDTH = 16;
    localparam int NREQ  = 4;
    localparam int ID_W  = 2;
    localparam int DELAY = 10;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic [NREQ-1:0]        req;
    logic [NREQ*WIDTH-1:0]  a_bus, b_bus;
    logic [NREQ-1:0]        gnt;
    logic                   busy, done;
    logic [ID_W-1:0]        done_id;
    logic [WIDTH-1:0]       ab_and, ab_or, ab_xor;

    logic [NREQ-1:0]        req1;
    logic [NREQ*WIDTH-1:0]  a_bus1, b_bus1;
    logic [NREQ-1:0]        gnt1;
    logic                   busy1, done1;
    logic [ID_W-1:0]        done_id1;
    logic [WIDTH-1:0]       ab_and1, ab_or1, ab_xor1;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int last_gnt_cyc = 0;

    typedef struct {
        logic [ID_W-1:0]  id;
        logic [WIDTH-1:0] a_v;
        logic [WIDTH-1:0] o_v;
        logic [WIDTH-1:0] x_v;
    } exp_t;

    exp_t sb[$];

    bitwise_oper_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .ID_W(ID_W), .DELAY(DELAY)) u_dut (
        .clock(clk), .reset_n(reset_n), .req(req), .a_bus(a_bus), .b_bus(b_bus),
        .gnt(gnt), .busy(busy), .done(done), .done_id(done_id),
        .ab_and(ab_and), .ab_or(ab_or), .ab_xor(ab_xor)
    );

    bitwise_oper_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .ID_W(ID_W), .DELAY(1)) u_dut1 (
        .clock(clk), .reset_n(reset_n), .req(req1), .a_bus(a_bus1), .b_bus(b_bus1),
        .gnt(gnt1), .busy(busy1), .done(done1), .done_id(done_id1),
        .ab_and(ab_and1), .ab_or(ab_or1), .ab_xor(ab_xor1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        exp_t e;
        e.id  = ID_W'(id);
        e.a_v = a & b;
        e.o_v = a | b;
        e.x_v = a ^ b;
        sb.push_back(e);
    endtask

    task automatic drive(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        a_bus[i*WIDTH +: WIDTH] = a;
        b_bus[i*WIDTH +: WIDTH] = b;
        req[i] = 1'b1;
    endtask

    // Waits (bounded) for a grant, checks it, drops the granted request.
    task automatic wait_gnt(input int exp_id, output int gcyc);
        bit seen = 1'b0;
        gcyc = -1;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (gnt !== '0) seen = 1'b1;
        end
        chk("gnt_seen", 32'(seen), 32'd1);
        if (seen) begin
            gcyc = cyc;
            $display("grant: cycle=%0d gnt=%b expected_id=%0d", cyc, gnt, exp_id);
            chk("gnt_onehot", 32'(gnt), 32'(1 << exp_id));
            chk("busy_at_gnt", 32'(busy), 32'd1);
            req = req & ~gnt;
            @(negedge clk);
            chk("gnt_pulse", 32'(gnt), 32'd0);
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && sb.size() != 0; n++) @(negedge clk);
        chk("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_gnt"},     32'(gnt),     32'd0);
        chk({tag, "_busy"},    32'(busy),    32'd0);
        chk({tag, "_done"},    32'(done),    32'd0);
        chk({tag, "_done_id"}, 32'(done_id), 32'd0);
        chk({tag, "_and"},     32'(ab_and),  32'd0);
        chk({tag, "_or"},      32'(ab_or),   32'd0);
        chk({tag, "_xor"},     32'(ab_xor),  32'd0);
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk_zero(tag);
        chk({tag, "_done1"}, 32'(done1), 32'd0);
        sb.delete();
        reset_n = 1'b1;
    endtask

    // Completion monitor: pops the scoreboard on every done pulse.
    initial begin
        exp_t e;
        logic prev_done;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            if (gnt !== '0) last_gnt_cyc = cyc;
            if (done === 1'b1) begin
                chk("done_not_back_to_back", 32'(prev_done), 32'd0);
                if (sb.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    $display("done: cycle=%0d id=%0d and=%h or=%h xor=%h", cyc, done_id, ab_and, ab_or, ab_xor);
                    chk("done_id", 32'(done_id), 32'(e.id));
                    chk("ab_and",  32'(ab_and),  32'(e.a_v));
                    chk("ab_or",   32'(ab_or),   32'(e.o_v));
                    chk("ab_xor",  32'(ab_xor),  32'(e.x_v));
                    chk("latency", 32'(cyc - last_gnt_cyc), 32'(DELAY));
                end
            end
            prev_done = done;
        end
    end

    initial begin
        int g0, g1, g2, g3;
        exp_t e;
        logic [WIDTH-1:0] ra [NREQ];
        logic [WIDTH-1:0] rb [NREQ];

        reset_n = 1'b0;
        req = '0; a_bus = '0; b_bus = '0;
        req1 = '0; a_bus1 = '0; b_bus1 = '0;
        @(negedge clk);
        do_reset("reset");

        // Single request, fixed operands with known results.
        drive(0, 16'hF0A7, 16'hA58C);
        e.id = 2'd0; e.a_v = 16'hA084; e.o_v = 16'hF5AF; e.x_v = 16'h552B;
        sb.push_back(e);
        wait_gnt(0, g0);
        chk("busy_mid", 32'(busy), 32'd1);
        drain();
        chk("busy_after_done", 32'(busy), 32'd0);

        // All four requesting from reset: order 0,1,2,3 spaced DELAY+1.
        do_reset("reset2");
        for (int i = 0; i < NREQ; i++) begin
            ra[i] = WIDTH'($urandom);
            rb[i] = WIDTH'($urandom);
            drive(i, ra[i], rb[i]);
            push(i, ra[i], rb[i]);
        end
        wait_gnt(0, g0);
        wait_gnt(1, g1);
        wait_gnt(2, g2);
        wait_gnt(3, g3);
        chk("spacing01", 32'(g1 - g0), 32'(DELAY + 1));
        chk("spacing12", 32'(g2 - g1), 32'(DELAY + 1));
        chk("spacing23", 32'(g3 - g2), 32'(DELAY + 1));
        drain();

        // Serve 2, then 1001 must go to 3 before 0.
        drive(2, 16'h1357, 16'h2468);
        push(2, 16'h1357, 16'h2468);
        wait_gnt(2, g0);
        drain();
        drive(3, 16'hAAAA, 16'h0F0F);
        drive(0, 16'h5555, 16'hFF00);
        push(3, 16'hAAAA, 16'h0F0F);
        push(0, 16'h5555, 16'hFF00);
        wait_gnt(3, g0);
        wait_gnt(0, g1);
        drain();

        // Extreme operands; changing them after the grant must not matter.
        drive(1, 16'hFFFF, 16'h0000);
        e.id = 2'd1; e.a_v = 16'h0000; e.o_v = 16'hFFFF; e.x_v = 16'hFFFF;
        sb.push_back(e);
        wait_gnt(1, g0);
        a_bus[1*WIDTH +: WIDTH] = 16'h1234;
        b_bus[1*WIDTH +: WIDTH] = 16'h5678;
        drain();

        // Reset in the middle of an operation: no done, pointer back to 0.
        drive(0, 16'hDEAD, 16'hBEEF);
        wait_gnt(0, g0);
        repeat (4) @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_zero("midreset");
        reset_n = 1'b1;
        for (int n = 0; n < 15; n++) begin
            @(negedge clk);
            chk("no_done_after_reset", 32'(done), 32'd0);
        end
        drive(1, 16'hC3C3, 16'h3C3C);
        drive(2, 16'h8001, 16'h8421);
        push(1, 16'hC3C3, 16'h3C3C);
        push(2, 16'h8001, 16'h8421);
        wait_gnt(1, g0);
        wait_gnt(2, g1);
        drain();

        // DELAY=1 instance with req[1] held: grant and done alternate.
        a_bus1[1*WIDTH +: WIDTH] = 16'h1234;
        b_bus1[1*WIDTH +: WIDTH] = 16'h00FF;
        req1[1] = 1'b1;
        begin
            bit seen = 1'b0;
            for (int n = 0; n < 10 && !seen; n++) begin
                @(negedge clk);
                if (gnt1 !== '0) seen = 1'b1;
            end
            chk("d1_gnt_seen", 32'(seen), 32'd1);
            if (seen) begin
                for (int k = 0; k < 8; k++) begin
                    if (k != 0) @(negedge clk);
                    $display("d1 step: k=%0d gnt=%b done=%b", k, gnt1, done1);
                    chk("d1_gnt",  32'(gnt1),  (k % 2 == 0) ? 32'b0010 : 32'd0);
                    chk("d1_done", 32'(done1), (k % 2 == 1) ? 32'd1 : 32'd0);
                    if (k % 2 == 1) begin
                        chk("d1_id",  32'(done_id1), 32'd1);
                        chk("d1_and", 32'(ab_and1),  32'h0034);
                        chk("d1_or",  32'(ab_or1),   32'h12FF);
                        chk("d1_xor", 32'(ab_xor1),  32'h12CB);
                    end
                end
            end
        end
        req1 = '0;
        repeat (3) @(negedge clk);
        chk("final_queue_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
